branch_ctrl: RTL and testbench

//  Drives the jumpEn/target inputs of the program counter: consumes programCounter and the

---
 rtl/branch_ctrl_if.sv | 35 +++
 rtl/branch_ctrl.sv | 108 ++++++++++
 tb/tb_branch_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_ctrl_if.sv
// Signal bundle between the instruction fetch path and branch_ctrl.
// The slave modport is the branch controller; the master is its environment (PC, ROM, ALU flags).
interface branch_ctrl_if #(
    parameter int D         = 10,
    parameter int W         = 9,
    parameter int LUT_DEPTH = 16,
    parameter int CNT_W     = 16
) ();
    localparam int AW = $clog2(LUT_DEPTH);

    logic [D-1:0]     programCounter;
    logic [W-1:0]     instr;
    logic             flagZero;
    logic             flagLt;
    logic             lutWrEn;
    logic [AW-1:0]    lutWrAddr;
    logic [D-1:0]     lutWrData;
    logic             start;
    logic             jumpEn;
    logic [D-1:0]     target;
    logic             halted;
    logic [CNT_W-1:0] takenCount;

    modport master (
        output programCounter, instr, flagZero, flagLt,
        output lutWrEn, lutWrAddr, lutWrData, start,
        input  jumpEn, target, halted, takenCount
    );

    modport slave (
        input  programCounter, instr, flagZero, flagLt,
        input  lutWrEn, lutWrAddr, lutWrData, start,
        output jumpEn, target, halted, takenCount
    );
endinterface

// File: rtl/branch_ctrl.sv
// Branch/jump resolver feeding the PC: target LUT lookup, HALT freeze with restart,
// and a saturating taken-branch counter.
module branch_ctrl #(
    parameter int D         = 10,
    parameter int W         = 9,
    parameter int LUT_DEPTH = 16,
    parameter int CNT_W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    branch_ctrl_if.slave bus
);
    localparam int AW = $clog2(LUT_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [D-1:0]     lut_q [LUT_DEPTH];
    logic [D-1:0]     lut_d [LUT_DEPTH];

    logic             is_branch;
    logic [1:0]       cond;
    logic [3:0]       idx;
    logic             cond_true;
    logic [D-1:0]     lut_rd;
    logic             jump;
    logic [D-1:0]     tgt;
    logic             halt_flag;

    assign is_branch = (bus.instr[W-1 -: 3] == 3'b111);
    assign cond      = bus.instr[5:4];
    assign idx       = bus.instr[3:0];
    // Combinational read sees the pre-edge contents, so a same-cycle write returns the old entry.
    assign lut_rd    = (int'(idx) < LUT_DEPTH) ? lut_q[idx] : '0;

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            2'b00:   cond_true = 1'b1;
            2'b01:   cond_true = bus.flagZero;
            2'b10:   cond_true = bus.flagLt;
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        lut_d = lut_q;
        if (bus.lutWrEn && ({1'b0, bus.lutWrAddr} < (AW+1)'(LUT_DEPTH)))
            lut_d[bus.lutWrAddr] = bus.lutWrData;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        jump      = 1'b0;
        tgt       = '0;
        halt_flag = 1'b0;
        case (state_q)
            RUN: begin
                if (is_branch) begin
                    if (cond == 2'b11) begin
                        jump    = 1'b1;
                        tgt     = bus.programCounter;
                        state_d = HALT;
                    end else if (cond_true) begin
                        jump = 1'b1;
                        tgt  = lut_rd;
                        if (count_q != {CNT_W{1'b1}})
                            count_d = count_q + CNT_W'(1);
                    end
                end
            end
            HALT: begin
                halt_flag = 1'b1;
                jump      = 1'b1;
                tgt       = bus.programCounter;
                if (bus.start) begin
                    tgt     = '0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        // The PC must not move while reset is asserted, whatever the ROM presents.
        if (!reset) begin
            jump = 1'b0;
            tgt  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            count_q <= '0;
            lut_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lut_q   <= lut_d;
        end
    end

    assign bus.jumpEn     = jump;
    assign bus.target     = tgt;
    assign bus.halted     = halt_flag;
    assign bus.takenCount = count_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl (CNT_W=4 build so saturation is reachable):
// a vector table for single-cycle decode plus hand sequences using a small PC model.
module tb_branch_ctrl;
    localparam int D = 10;
    localparam int W = 9;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    branch_ctrl_if #(.D(D), .W(W), .LUT_DEPTH(16), .CNT_W(CW)) bus ();
    branch_ctrl #(.D(D), .W(W), .LUT_DEPTH(16), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [D-1:0]  pc;
        logic [W-1:0]  ins;
        logic          fz;
        logic          fl;
        logic          we;
        logic [3:0]    wa;
        logic [D-1:0]  wd;
        logic          st;
        logic          ej;
        logic [D-1:0]  et;
        logic          eh;
        logic [CW-1:0] ec;
    } vec_t;

    localparam logic [W-1:0] NOP   = 9'b000_00_0000;
    localparam logic [W-1:0] BA3   = 9'b111_00_0011;
    localparam logic [W-1:0] BZ5   = 9'b111_01_0101;
    localparam logic [W-1:0] BL5   = 9'b111_10_0101;
    localparam logic [W-1:0] BA2   = 9'b111_00_0010;
    localparam logic [W-1:0] BA4   = 9'b111_00_0100;
    localparam logic [W-1:0] OTHER = 9'b110_00_0010;
    localparam logic [W-1:0] HLT   = 9'b111_11_0000;

    int n_checks = 0;
    int n_fail = 0;
    logic [D-1:0]  pc;
    logic [CW-1:0] exp_cnt;
    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [D-1:0] p, input logic [W-1:0] i, input logic fz,
                                input logic fl, input logic we, input logic [3:0] wa,
                                input logic [D-1:0] wd, input logic st, input logic ej,
                                input logic [D-1:0] et, input logic eh, input logic [CW-1:0] ec);
        vec_t v;
        v.pc = p; v.ins = i; v.fz = fz; v.fl = fl; v.we = we; v.wa = wa; v.wd = wd;
        v.st = st; v.ej = ej; v.et = et; v.eh = eh; v.ec = ec;
        return v;
    endfunction

    // Advance one clock with the PC model: load target on jumpEn, else increment.
    task automatic tick();
        logic          j;
        logic [D-1:0]  t;
        j = bus.jumpEn;
        t = bus.target;
        @(posedge clk);
        #1;
        pc = j ? t : pc + 10'd1;
        bus.programCounter = pc;
    endtask

    initial begin
        vecs[0]  = mk(10'd0,  NOP,   1'b0, 1'b0, 1'b1, 4'd3, 10'd11, 1'b0, 1'b0, 10'd0,  1'b0, 4'd0);
        vecs[1]  = mk(10'd1,  NOP,   1'b0, 1'b0, 1'b1, 4'd5, 10'd40, 1'b0, 1'b0, 10'd0,  1'b0, 4'd0);
        vecs[2]  = mk(10'd2,  NOP,   1'b0, 1'b0, 1'b1, 4'd2, 10'd9,  1'b0, 1'b0, 10'd0,  1'b0, 4'd0);
        vecs[3]  = mk(10'd4,  BA3,   1'b0, 1'b0, 1'b0, 4'd0, 10'd0,  1'b0, 1'b1, 10'd11, 1'b0, 4'd0);
        vecs[4]  = mk(10'd11, BZ5,   1'b0, 1'b0, 1'b0, 4'd0, 10'd0,  1'b0, 1'b0, 10'd0,  1'b0, 4'd1);
        vecs[5]  = mk(10'd12, BZ5,   1'b1, 1'b0, 1'b0, 4'd0, 10'd0,  1'b0, 1'b1, 10'd40, 1'b0, 4'd1);
        vecs[6]  = mk(10'd40, BL5,   1'b1, 1'b0, 1'b0, 4'd0, 10'd0,  1'b0, 1'b0, 10'd0,  1'b0, 4'd2);
        vecs[7]  = mk(10'd41, BL5,   1'b0, 1'b1, 1'b0, 4'd0, 10'd0,  1'b0, 1'b1, 10'd40, 1'b0, 4'd2);
        vecs[8]  = mk(10'd40, BA2,   1'b0, 1'b0, 1'b1, 4'd2, 10'd7,  1'b0, 1'b1, 10'd9,  1'b0, 4'd3);
        vecs[9]  = mk(10'd9,  BA2,   1'b0, 1'b0, 1'b0, 4'd0, 10'd0,  1'b0, 1'b1, 10'd7,  1'b0, 4'd4);
        vecs[10] = mk(10'd7,  OTHER, 1'b1, 1'b1, 1'b0, 4'd0, 10'd0,  1'b0, 1'b0, 10'd0,  1'b0, 4'd5);
        vecs[11] = mk(10'd8,  NOP,   1'b0, 1'b0, 1'b0, 4'd0, 10'd0,  1'b1, 1'b0, 10'd0,  1'b0, 4'd5);
        vecs[12] = mk(10'd20, HLT,   1'b0, 1'b0, 1'b1, 4'd4, 10'd33, 1'b0, 1'b1, 10'd20, 1'b0, 4'd5);
        vecs[13] = mk(10'd20, BA4,   1'b1, 1'b1, 1'b0, 4'd0, 10'd0,  1'b0, 1'b1, 10'd20, 1'b1, 4'd5);
        vecs[14] = mk(10'd20, BA4,   1'b0, 1'b0, 1'b0, 4'd0, 10'd0,  1'b1, 1'b1, 10'd0,  1'b1, 4'd5);
        vecs[15] = mk(10'd0,  BA4,   1'b0, 1'b0, 1'b0, 4'd0, 10'd0,  1'b0, 1'b1, 10'd33, 1'b0, 4'd5);
        vecs[16] = mk(10'd33, NOP,   1'b0, 1'b0, 1'b0, 4'd0, 10'd0,  1'b0, 1'b0, 10'd0,  1'b0, 4'd6);

        // Reset held with a branch-always on the bus: outputs must stay quiet.
        pc = '0;
        bus.programCounter = pc;
        bus.instr = BA3;
        bus.flagZero = 1'b0;
        bus.flagLt = 1'b0;
        bus.lutWrEn = 1'b0;
        bus.lutWrAddr = '0;
        bus.lutWrData = '0;
        bus.start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rst_jumpEn", 32'(bus.jumpEn), 32'd0);
            check("rst_target", 32'(bus.target), 32'd0);
            check("rst_halted", 32'(bus.halted), 32'd0);
            check("rst_count", 32'(bus.takenCount), 32'd0);
            $display("reset cycle %0d: jumpEn=%0d takenCount=%0d", c, bus.jumpEn, bus.takenCount);
        end
        @(posedge clk);
        #1;
        bus.instr = NOP;
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            bus.programCounter = vecs[i].pc;
            bus.instr = vecs[i].ins;
            bus.flagZero = vecs[i].fz;
            bus.flagLt = vecs[i].fl;
            bus.lutWrEn = vecs[i].we;
            bus.lutWrAddr = vecs[i].wa;
            bus.lutWrData = vecs[i].wd;
            bus.start = vecs[i].st;
            @(negedge clk);
            $display("vec %0d: pc=%0d instr=%b jumpEn=%0d target=%0d halted=%0d count=%0d",
                     i, vecs[i].pc, vecs[i].ins, bus.jumpEn, bus.target, bus.halted, bus.takenCount);
            check($sformatf("vec%0d_jumpEn", i), 32'(bus.jumpEn), 32'(vecs[i].ej));
            check($sformatf("vec%0d_target", i), 32'(bus.target), 32'(vecs[i].et));
            check($sformatf("vec%0d_halted", i), 32'(bus.halted), 32'(vecs[i].eh));
            check($sformatf("vec%0d_count", i), 32'(bus.takenCount), 32'(vecs[i].ec));
            @(posedge clk);
            #1;
        end
        bus.lutWrEn = 1'b0;
        bus.start = 1'b0;
        exp_cnt = 4'd6;

        // Branch with the PC model: PC=4 -> 11 with zero delay slots.
        pc = 10'd4;
        bus.programCounter = pc;
        bus.instr = BA3;
        @(negedge clk);
        tick();
        exp_cnt = exp_cnt + 4'd1;
        $display("branch idx3 from pc 4: pc=%0d count=%0d", pc, bus.takenCount);
        check("pcm_branch_pc", 32'(pc), 32'd11);
        check("pcm_branch_count", 32'(bus.takenCount), 32'(exp_cnt));

        // HALT at PC=20: freeze for 10 cycles, then restart to 0.
        pc = 10'd20;
        bus.programCounter = pc;
        bus.instr = HLT;
        @(negedge clk);
        tick();
        bus.instr = BA3;
        bus.flagZero = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("halt_flag", 32'(bus.halted), 32'd1);
            check("halt_pc", 32'(pc), 32'd20);
            $display("halt cycle %0d: pc=%0d halted=%0d", c, pc, bus.halted);
            tick();
        end
        bus.start = 1'b1;
        @(negedge clk);
        check("restart_target", 32'(bus.target), 32'd0);
        tick();
        bus.start = 1'b0;
        bus.instr = NOP;
        bus.flagZero = 1'b0;
        @(negedge clk);
        $display("restart: pc=%0d halted=%0d count=%0d", pc, bus.halted, bus.takenCount);
        check("restart_pc", 32'(pc), 32'd0);
        check("restart_halted", 32'(bus.halted), 32'd0);
        check("restart_count", 32'(bus.takenCount), 32'(exp_cnt));
        @(posedge clk);
        #1;

        // 16 taken branches: counter must stop at 15.
        bus.instr = BA3;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            tick();
            if (exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
            $display("sat branch %0d: count=%0d", c, bus.takenCount);
            check("sat_count", 32'(bus.takenCount), 32'(exp_cnt));
        end
        check("sat_final", 32'(bus.takenCount), 32'd15);

        // Asynchronous reset between edges clears everything immediately.
        #2;
        bus.start = 1'b1;
        reset = 1'b0;
        #1;
        $display("async reset: count=%0d jumpEn=%0d target=%0d", bus.takenCount, bus.jumpEn, bus.target);
        check("areset_count", 32'(bus.takenCount), 32'd0);
        check("areset_jumpEn", 32'(bus.jumpEn), 32'd0);
        check("areset_target", 32'(bus.target), 32'd0);
        check("areset_halted", 32'(bus.halted), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_jumpEn", 32'(bus.jumpEn), 32'd1);
        check("post_reset_lut3", 32'(bus.target), 32'd0);
        check("post_reset_count", 32'(bus.takenCount), 32'd0);
        tick();
        $display("after reset branch: count=%0d", bus.takenCount);
        check("post_reset_count1", 32'(bus.takenCount), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
